// File: rtl/rx_echo_queue.sv
// Receive-to-transmit buffering stage: queues RX bytes in a circular FIFO and
// drains them one per transmitter handshake, with optional ASCII case swap.
module rx_echo_queue #(
   parameter int unsigned DEPTH_LOG2   = 4,
   parameter int unsigned BUSY_TIMEOUT = 16,
   parameter int unsigned CASE_SWAP    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            RX_DATA,
   input  logic                  RX_STATUS,
   input  logic                  TX_STATUS,
   output logic [7:0]            TX_DATA,
   output logic                  TX_EN,
   output logic                  overflow,
   output logic [DEPTH_LOG2:0]   fill_level
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2;
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
   localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [7:0]         mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   busy_cnt;
   logic               full;
   logic               empty;
   logic               pop;
   logic               push;

   // Swap letter case only inside the two ASCII letter ranges.
   function automatic logic [7:0] swap_case(input logic [7:0] b);
      if ((CASE_SWAP != 0) &&
          (((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A))))
         return b ^ 8'h20;
      return b;
   endfunction

   assign full  = (fill_level == LVL_W'(DEPTH));
   assign empty = (fill_level == '0);
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push  = RX_STATUS && (!full || pop);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and pop decision.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && TX_STATUS) begin
               pop       = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD:      state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (!TX_STATUS)
               state_nxt = WAIT_DONE;
            else if (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1))
               state_nxt = IDLE;
         end
         WAIT_DONE: begin
            if (TX_STATUS) state_nxt = IDLE;
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // FIFO storage; contents are meaningless after reset since pointers clear.
   always_ff @(posedge clk) begin
      if (!reset && push) mem[wr_ptr] <= RX_DATA;
   end

   // Pointers, occupancy, sticky overflow, timeout counter and TX outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         overflow   <= 1'b0;
         TX_EN      <= 1'b0;
         TX_DATA    <= 8'h00;
         busy_cnt   <= '0;
      end else begin
         TX_EN <= pop;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (RX_STATUS && !push) overflow <= 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            TX_DATA <= swap_case(mem[rd_ptr]);
         end
         case ({push, pop})
            2'b10:   fill_level <= fill_level + LVL_W'(1);
            2'b01:   fill_level <= fill_level - LVL_W'(1);
            default: fill_level <= fill_level;
         endcase
         if (state == LOAD)
            busy_cnt <= '0;
         else if ((state == WAIT_BUSY) && TX_STATUS)
            busy_cnt <= busy_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rx_echo_queue.sv
// Directed self-checking bench for rx_echo_queue; a second instance with
// CASE_SWAP=1 shares the stimulus so both output mappings are checked.
module tb_rx_echo_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_status;
   logic       tx_status;
   logic [7:0] tx_data, tx_data_sw;
   logic       tx_en, tx_en_sw;
   logic       overflow, overflow_sw;
   logic [4:0] fill_level, fill_level_sw;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   rx_echo_queue #(.DEPTH_LOG2(4), .BUSY_TIMEOUT(16), .CASE_SWAP(0)) u_dut (
      .clk(clk), .reset(reset), .RX_DATA(rx_data), .RX_STATUS(rx_status),
      .TX_STATUS(tx_status), .TX_DATA(tx_data), .TX_EN(tx_en),
      .overflow(overflow), .fill_level(fill_level)
   );

   rx_echo_queue #(.DEPTH_LOG2(4), .BUSY_TIMEOUT(16), .CASE_SWAP(1)) u_dut_sw (
      .clk(clk), .reset(reset), .RX_DATA(rx_data), .RX_STATUS(rx_status),
      .TX_STATUS(tx_status), .TX_DATA(tx_data_sw), .TX_EN(tx_en_sw),
      .overflow(overflow_sw), .fill_level(fill_level_sw)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transmitter model: wait for TX_EN, check the byte, go busy, then idle again.
   task automatic drain_one(input logic [7:0] exp, input logic [7:0] exp_sw, input int busy);
      tx_status = 1'b1;
      for (int i = 0; i < 60 && tx_en !== 1'b1; i++) tick();
      check("drain_tx_en", 32'(tx_en), 1);
      check("drain_data", 32'(tx_data), 32'(exp));
      check("drain_data_sw", 32'(tx_data_sw), 32'(exp_sw));
      tx_status = 1'b0;
      tick();
      check("tx_en_one_cycle", 32'(tx_en), 0);
      for (int i = 1; i < busy; i++) tick();
      tx_status = 1'b1;
      tick();
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_data   = b;
      rx_status = 1'b1;
      tick();
      rx_status = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rx_data = 8'h00; rx_status = 1'b0; tx_status = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_fill", 32'(fill_level), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_tx_en", 32'(tx_en), 0);
      check("rst_tx_data", 32'(tx_data), 0);

      // Single byte latency: TX_EN in the second cycle after the push edge.
      tx_status = 1'b1;
      push_byte(8'h41);
      check("lat_fill1", 32'(fill_level), 1);
      check("lat_no_early_en", 32'(tx_en), 0);
      tick();
      check("lat_tx_en", 32'(tx_en), 1);
      check("lat_data", 32'(tx_data), 32'h41);
      check("lat_data_sw", 32'(tx_data_sw), 32'h61);
      check("lat_fill0", 32'(fill_level), 0);
      tx_status = 1'b0;
      tick();
      check("lat_en_drop", 32'(tx_en), 0);
      tick();
      tx_status = 1'b1;
      tick(); tick();
      check("lat_no_second", 32'(tx_en), 0);

      // Overflow: 20 pushes into a 16-deep FIFO with the transmitter busy.
      tx_status = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rx_data = 8'(i); rx_status = 1'b1;
         tick();
         if (i == 15) begin
            check("ovf_full16", 32'(fill_level), 16);
            check("ovf_not_yet", 32'(overflow), 0);
         end
         if (i == 16) check("ovf_set", 32'(overflow), 1);
      end
      rx_status = 1'b0;
      check("ovf_fill_sat", 32'(fill_level), 16);
      for (int i = 0; i < 16; i++) drain_one(8'(i), 8'(i), 3);
      n = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (tx_en) n++; end
      check("ovf_no_extra", n, 0);
      check("ovf_empty", 32'(fill_level), 0);
      check("ovf_sticky", 32'(overflow), 1);
      reset = 1'b1; tick(); reset = 1'b0;
      check("ovf_cleared", 32'(overflow), 0);

      // Case-swap boundaries around both letter ranges.
      tx_status = 1'b0;
      push_byte(8'h40); push_byte(8'h5B); push_byte(8'h7A); push_byte(8'h60); push_byte(8'h5A);
      drain_one(8'h40, 8'h40, 3);
      drain_one(8'h5B, 8'h5B, 3);
      drain_one(8'h7A, 8'h5A, 3);
      drain_one(8'h60, 8'h60, 3);
      drain_one(8'h5A, 8'h7A, 3);

      // Wrap-around: 4 bursts of 10, transmitter busy 10 cycles per byte.
      for (int b = 0; b < 4; b++) begin
         tx_status = 1'b0;
         for (int i = 0; i < 10; i++) push_byte(8'(8'h80 + b * 10 + i));
         check("wrap_fill10", 32'(fill_level), 10);
         for (int i = 0; i < 10; i++) drain_one(8'(8'h80 + b * 10 + i), 8'(8'h80 + b * 10 + i), 10);
      end
      check("wrap_overflow", 32'(overflow), 0);
      check("wrap_empty", 32'(fill_level), 0);

      // Push into a full FIFO in the same cycle as the pop.
      tx_status = 1'b0;
      for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i));
      check("sim_full", 32'(fill_level), 16);
      rx_data = 8'h55; rx_status = 1'b1; tx_status = 1'b1;
      tick();
      rx_status = 1'b0;
      check("sim_fill", 32'(fill_level), 16);
      check("sim_overflow", 32'(overflow), 0);
      check("sim_tx_en", 32'(tx_en), 1);
      for (int i = 0; i < 16; i++) drain_one(8'(8'h30 + i), 8'(8'h30 + i), 3);
      drain_one(8'h55, 8'h75, 3);
      check("sim_empty", 32'(fill_level), 0);
      check("sim_overflow_end", 32'(overflow), 0);

      // Busy timeout: TX_STATUS never falls, next byte follows 18 cycles later.
      tx_status = 1'b1;
      push_byte(8'h61);
      rx_data = 8'h62; rx_status = 1'b1;
      tick();
      rx_status = 1'b0;
      check("to_first_en", 32'(tx_en), 1);
      check("to_first_data", 32'(tx_data), 32'h61);
      check("to_first_sw", 32'(tx_data_sw), 32'h41);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick(); n++;
         if (tx_en) break;
      end
      check("to_gap", n, 18);
      check("to_second_data", 32'(tx_data), 32'h62);
      check("to_second_sw", 32'(tx_data_sw), 32'h42);
      tx_status = 1'b0;
      tick(); tick();
      tx_status = 1'b1;
      tick();
      check("to_empty", 32'(fill_level), 0);

      // Reset during WAIT_DONE with 5 entries still queued.
      tx_status = 1'b0;
      for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i));
      tx_status = 1'b1;
      tick();
      check("rw_load", 32'(tx_en), 1);
      tx_status = 1'b0;
      tick(); tick();
      check("rw_fill5", 32'(fill_level), 5);
      reset = 1'b1; tx_status = 1'b1; rx_data = 8'hAA; rx_status = 1'b1;
      tick();
      reset = 1'b0; rx_status = 1'b0;
      check("rw_fill0", 32'(fill_level), 0);
      check("rw_tx_en", 32'(tx_en), 0);
      check("rw_tx_data", 32'(tx_data), 0);
      check("rw_overflow", 32'(overflow), 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (tx_en) n++; end
      check("rw_silent", n, 0);
      check("rw_still_empty", 32'(fill_level), 0);
      push_byte(8'h7B);
      drain_one(8'h7B, 8'h7B, 3);
      check("rw_final_empty", 32'(fill_level), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
